// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Write pulses the cycle after the 4th byte; s_ready drops during WRITE/IDLE/DONE so bytes wait.
module imem_loader #(
    parameter int Width    = 32,
    parameter int MemBytes = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] base_addr,
    input  logic [10:0]      word_count,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    localparam int ExtW = Width + 13;

    state_t          state, state_nxt;
    logic [Width-1:0] addr;
    logic [10:0]     remaining;
    logic [1:0]      byte_cnt;
    logic [23:0]     low_bytes;
    logic [ExtW-1:0] end_addr;
    logic            misaligned, out_of_range, reject, hs;

    // Range check is done wide enough that base+4*count cannot overflow.
    assign end_addr     = ExtW'(base_addr) + (ExtW'(word_count) << 2);
    assign out_of_range = end_addr > ExtW'(MemBytes);
    assign misaligned   = base_addr[1:0] != 2'b00;
    assign reject       = misaligned || out_of_range;
    assign hs           = s_valid && s_ready;
    assign cpu_hold     = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !reject)
                    state_nxt = (word_count == 11'd0) ? DONE : COLLECT;
            end
            COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = (remaining == 11'd1) ? DONE : COLLECT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            low_bytes <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= reject;
                        if (!reject) begin
                            addr      <= base_addr;
                            remaining <= word_count;
                            byte_cnt  <= 2'd0;
                        end
                    end
                end
                COLLECT: begin
                    if (hs) begin
                        // The 4th byte goes straight into the write register so the
                        // memory sees a stable address/data for the WRITE cycle.
                        if (byte_cnt == 2'd3) begin
                            mem_addr  <= addr;
                            mem_wdata <= Width'({s_data, low_bytes});
                        end else begin
                            low_bytes[{byte_cnt, 3'b000} +: 8] <= s_data;
                        end
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    addr      <= addr + Width'(4);
                    remaining <= remaining - 11'd1;
                    byte_cnt  <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
